zxw_dm_arbiter: RTL and testbench

//  Shares the single data-memory/cache port (zxw_cram_v) between two requesters:
//  A (CPU load/store) and B (DMA/IO). Grants one request at a time, drives the

---
 rtl/zxw_dm_arbiter_if.sv | 40 ++++
 rtl/zxw_dm_arbiter.sv | 174 +++++++++++++++++
 tb/tb_zxw_dm_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/zxw_dm_arbiter_if.sv
// Bus bundle between the two requesters (A = CPU load/store, B = DMA/IO),
// the data-memory arbiter and the cache port.
interface zxw_dm_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 14
);
  logic          req_a;
  logic          req_b;
  logic          wr_a;
  logic          wr_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_a;
  logic [DW-1:0] wdata_b;
  logic          ack_a;
  logic          ack_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic          mem_stall;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          timeout_err;

  modport slave (
    input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
    input  mem_stall, mem_rdata,
    output ack_a, ack_b, rdata_a, rdata_b,
    output mem_addr, mem_wdata, mem_wr, busy, timeout_err
  );

  modport master (
    output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
    output mem_stall, mem_rdata,
    input  ack_a, ack_b, rdata_a, rdata_b,
    input  mem_addr, mem_wdata, mem_wr, busy, timeout_err
  );
endinterface

// File: rtl/zxw_dm_arbiter.sv
// Shares the single data-memory/cache port between requesters A and B: one access
// at a time, held on mem_* until the cache stops stalling or the wait times out.
module zxw_dm_arbiter #(
  parameter int AW         = 14,
  parameter int DW         = 14,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic            Clock,
  input  logic            Resetn,
  zxw_dm_arbiter_if.slave bus
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  localparam bit   FIXED = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [TW-1:0] tcnt_r, tcnt_s;
  logic          last_r, last_s;
  logic          own_r, own_s;
  logic          ack_a_r, ack_a_s, ack_b_r, ack_b_s;
  logic          tmo_r, tmo_s;
  logic          busy_r, busy_s;
  logic          mem_wr_r, mem_wr_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic [DW-1:0] rdata_a_r, rdata_a_s, rdata_b_r, rdata_b_s;
  logic          elig_a_s, elig_b_s, grant_a_s, grant_b_s, done_s;

  assign bus.ack_a       = ack_a_r;
  assign bus.ack_b       = ack_b_r;
  assign bus.rdata_a     = rdata_a_r;
  assign bus.rdata_b     = rdata_b_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.mem_wr      = mem_wr_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = tmo_r;

  // Next-state, arbitration and output logic for the IDLE/ISSUE/WAIT sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    tcnt_s      = tcnt_r;
    last_s      = last_r;
    own_s       = own_r;
    ack_a_s     = 1'b0;
    ack_b_s     = 1'b0;
    tmo_s       = 1'b0;
    busy_s      = busy_r;
    mem_wr_s    = mem_wr_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    rdata_a_s   = rdata_a_r;
    rdata_b_s   = rdata_b_r;
    done_s      = 1'b0;

    // A port is not re-granted in the cycle its ack is being presented.
    elig_a_s = bus.req_a && !ack_a_r;
    elig_b_s = bus.req_b && !ack_b_r;
    if (FIXED) begin
      grant_a_s = elig_a_s;
      grant_b_s = elig_b_s && !bus.req_a;
    end else begin
      grant_a_s = elig_a_s && (!elig_b_s || (last_r == OWN_B));
      grant_b_s = elig_b_s && !grant_a_s;
    end

    case (state_r)
      ST_IDLE: begin
        if (grant_a_s || grant_b_s) begin
          own_s       = grant_b_s ? OWN_B : OWN_A;
          mem_addr_s  = grant_b_s ? bus.addr_b : bus.addr_a;
          mem_wdata_s = grant_b_s ? bus.wdata_b : bus.wdata_a;
          mem_wr_s    = grant_b_s ? bus.wr_b : bus.wr_a;
          busy_s      = 1'b1;
          cnt_s       = '0;
          state_s     = ST_ISSUE;
        end else begin
          mem_wr_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (cnt_r == CNT_LAST) begin
          if (bus.mem_stall) begin
            tcnt_s  = '0;
            state_s = ST_WAIT;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.mem_stall) begin
          done_s = 1'b1;
        end else if (tcnt_r == TCNT_LAST) begin
          done_s = 1'b1;
          tmo_s  = 1'b1;
        end else begin
          tcnt_s = tcnt_r + TW'(1);
        end
      end
      default: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        mem_wr_s = 1'b0;
      end
    endcase

    // Completion: ack the owner, capture read data, release the port.
    if (done_s) begin
      ack_a_s = (own_r == OWN_A);
      ack_b_s = (own_r == OWN_B);
      if (mem_wr_r) begin
        rdata_a_s = rdata_a_r;
      end else if (own_r == OWN_B) begin
        rdata_b_s = bus.mem_rdata;
      end else begin
        rdata_a_s = bus.mem_rdata;
      end
      mem_wr_s = 1'b0;
      busy_s   = 1'b0;
      last_s   = own_r;
      state_s  = ST_IDLE;
    end else begin
      last_s = last_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      tcnt_r      <= '0;
      last_r      <= OWN_B;
      own_r       <= OWN_A;
      ack_a_r     <= 1'b0;
      ack_b_r     <= 1'b0;
      tmo_r       <= 1'b0;
      busy_r      <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rdata_a_r   <= '0;
      rdata_b_r   <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tcnt_r      <= tcnt_s;
      last_r      <= last_s;
      own_r       <= own_s;
      ack_a_r     <= ack_a_s;
      ack_b_r     <= ack_b_s;
      tmo_r       <= tmo_s;
      busy_r      <= busy_s;
      mem_wr_r    <= mem_wr_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      rdata_a_r   <= rdata_a_s;
      rdata_b_r   <= rdata_b_s;
    end
  end
endmodule

// File: tb/tb_zxw_dm_arbiter.sv
// Bench for zxw_dm_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream and are checked every cycle against an access-age model.
module tb_zxw_dm_arbiter;
  localparam int AW = 14;
  localparam int DW = 14;
  localparam int SETTLE = 2;
  localparam int TIMEOUT = 64;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  logic          req_a, req_b, wr_a, wr_b, mem_stall;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b, mem_rdata;

  zxw_dm_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
  zxw_dm_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  assign bus0.req_a = req_a;     assign bus1.req_a = req_a;
  assign bus0.req_b = req_b;     assign bus1.req_b = req_b;
  assign bus0.wr_a = wr_a;       assign bus1.wr_a = wr_a;
  assign bus0.wr_b = wr_b;       assign bus1.wr_b = wr_b;
  assign bus0.addr_a = addr_a;   assign bus1.addr_a = addr_a;
  assign bus0.addr_b = addr_b;   assign bus1.addr_b = addr_b;
  assign bus0.wdata_a = wdata_a; assign bus1.wdata_a = wdata_a;
  assign bus0.wdata_b = wdata_b; assign bus1.wdata_b = wdata_b;
  assign bus0.mem_stall = mem_stall; assign bus1.mem_stall = mem_stall;
  assign bus0.mem_rdata = mem_rdata; assign bus1.mem_rdata = mem_rdata;

  zxw_dm_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .FIXED_PRIO(0))
    dut0 (.Clock(Clock), .Resetn(Resetn), .bus(bus0));
  zxw_dm_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .FIXED_PRIO(1))
    dut1 (.Clock(Clock), .Resetn(Resetn), .bus(bus1));

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is described only by its owner and its age in edges since grant.
  typedef struct packed {
    logic          busy, own, last, ack_a, ack_b, tmo, mem_wr;
    logic [15:0]   age;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata_a, rdata_b;
  } model_t;
  model_t m0, m1;

  function automatic model_t model_next(model_t s, bit fixed);
    model_t n;
    logic ea, eb, pick_b;
    n = s;
    n.ack_a = 1'b0;
    n.ack_b = 1'b0;
    n.tmo = 1'b0;
    if (!Resetn) begin
      n = '0;
      n.last = 1'b1;
    end else if (s.busy) begin
      n.age = s.age + 16'd1;
      if (n.age >= 16'(SETTLE) && (!mem_stall || n.age == 16'(SETTLE + TIMEOUT))) begin
        n.tmo = mem_stall;
        n.ack_a = !s.own;
        n.ack_b = s.own;
        if (!s.mem_wr) begin
          if (s.own) n.rdata_b = mem_rdata;
          else n.rdata_a = mem_rdata;
        end
        n.busy = 1'b0;
        n.mem_wr = 1'b0;
        n.last = s.own;
      end
    end else begin
      ea = req_a && !s.ack_a;
      eb = req_b && !s.ack_b;
      if (fixed) pick_b = eb && !req_a;
      else pick_b = eb && (!ea || !s.last);
      if (ea || pick_b) begin
        n.busy = 1'b1;
        n.age = 16'd0;
        n.own = pick_b;
        n.mem_addr = pick_b ? addr_b : addr_a;
        n.mem_wdata = pick_b ? wdata_b : wdata_a;
        n.mem_wr = pick_b ? wr_b : wr_a;
      end else begin
        n.mem_wr = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge Clock) begin
    m0 <= model_next(m0, 1'b0);
    m1 <= model_next(m1, 1'b1);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      chk("d0_ctl", 32'({bus0.ack_a, bus0.ack_b, bus0.busy, bus0.timeout_err, bus0.mem_wr}),
          32'({m0.ack_a, m0.ack_b, m0.busy, m0.tmo, m0.mem_wr}));
      chk("d0_mem_addr", 32'(bus0.mem_addr), 32'(m0.mem_addr));
      chk("d0_mem_wdata", 32'(bus0.mem_wdata), 32'(m0.mem_wdata));
      chk("d0_rdata_a", 32'(bus0.rdata_a), 32'(m0.rdata_a));
      chk("d0_rdata_b", 32'(bus0.rdata_b), 32'(m0.rdata_b));
      chk("d1_ctl", 32'({bus1.ack_a, bus1.ack_b, bus1.busy, bus1.timeout_err, bus1.mem_wr}),
          32'({m1.ack_a, m1.ack_b, m1.busy, m1.tmo, m1.mem_wr}));
      chk("d1_mem_addr", 32'(bus1.mem_addr), 32'(m1.mem_addr));
      chk("d1_mem_wdata", 32'(bus1.mem_wdata), 32'(m1.mem_wdata));
      chk("d1_rdata_a", 32'(bus1.rdata_a), 32'(m1.rdata_a));
      chk("d1_rdata_b", 32'(bus1.rdata_b), 32'(m1.rdata_b));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  initial begin
    req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0; mem_stall = 1'b0;
    addr_a = 14'h0000; addr_b = 14'h0000; wdata_a = 14'h0000; wdata_b = 14'h0000;
    mem_rdata = 14'h0000;
    Resetn = 1'b0;
    tick(2);
    chk_en = 1'b1;
    chk("rst_ctl", 32'({bus0.ack_a, bus0.ack_b, bus0.busy, bus0.mem_wr, bus0.timeout_err}), 32'd0);
    chk("rst_addr", 32'(bus0.mem_addr), 32'd0);
    Resetn = 1'b1;
    tick(1);

    // A read, no stall
    req_a = 1'b1; wr_a = 1'b0; addr_a = 14'h0123; mem_rdata = 14'h2AAA;
    tick(1);
    chk("t1_grant_addr", 32'(bus0.mem_addr), 32'h0123);
    chk("t1_busy", 32'(bus0.busy), 32'd1);
    chk("t1_wr", 32'(bus0.mem_wr), 32'd0);
    tick(1);
    chk("t1_early_ack", 32'(bus0.ack_a), 32'd0);
    tick(1);
    chk("t1_ack_a", 32'(bus0.ack_a), 32'd1);
    chk("t1_ack_b", 32'(bus0.ack_b), 32'd0);
    chk("t1_rdata_a", 32'(bus0.rdata_a), 32'h2AAA);
    chk("t1_wr_end", 32'(bus0.mem_wr), 32'd0);
    req_a = 1'b0;
    tick(1);

    // B write through a long stall
    req_b = 1'b1; wr_b = 1'b1; addr_b = 14'h2A10; wdata_b = 14'h1555;
    mem_stall = 1'b1; mem_rdata = 14'h3333;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      chk("t2_wr_held", 32'(bus0.mem_wr), 32'd1);
      chk("t2_no_ack", 32'(bus0.ack_b), 32'd0);
    end
    mem_stall = 1'b0;
    tick(1);
    chk("t2_ack_b", 32'(bus0.ack_b), 32'd1);
    chk("t2_wr_end", 32'(bus0.mem_wr), 32'd0);
    chk("t2_rdata_b", 32'(bus0.rdata_b), 32'd0);
    chk("t2_wdata", 32'(bus0.mem_wdata), 32'h1555);
    req_b = 1'b0; wr_b = 1'b0;
    tick(1);

    // Both requesting from reset: alternation (RR) vs A-only (fixed)
    Resetn = 1'b0; req_a = 1'b1; req_b = 1'b1;
    addr_a = 14'h0AAA; addr_b = 14'h0BBB; mem_rdata = 14'h0155;
    tick(1);
    Resetn = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      chk("t3_rr_ack_a", 32'(bus0.ack_a), 32'(j % 6 == 2));
      chk("t3_rr_ack_b", 32'(bus0.ack_b), 32'(j % 6 == 5));
      chk("t3_fx_ack_a", 32'(bus1.ack_a), 32'(j % 4 == 2));
      chk("t3_fx_ack_b", 32'(bus1.ack_b), 32'd0);
      if (j == 3) begin
        chk("t3_rr_addr_b", 32'(bus0.mem_addr), 32'h0BBB);
        chk("t3_fx_addr_a", 32'(bus1.mem_addr), 32'h0AAA);
      end
    end
    req_a = 1'b0;
    tick(3);
    chk("t4_fx_ack_b", 32'(bus1.ack_b), 32'd1);
    chk("t4_rr_no_ack_b", 32'(bus0.ack_b), 32'd0);
    req_b = 1'b0;
    tick(1);
    chk("t4_rr_ack_b_dropped", 32'(bus0.ack_b), 32'd1);
    chk("t4_rr_rdata_b", 32'(bus0.rdata_b), 32'h0155);
    tick(1);
    chk("t4_idle", 32'({bus0.busy, bus1.busy}), 32'd0);

    // Stall stuck high: forced completion
    req_a = 1'b1; wr_a = 1'b0; addr_a = 14'h3FFF; mem_stall = 1'b1; mem_rdata = 14'h1234;
    tick(1);
    tick(65);
    chk("t5_pre_tmo", 32'(bus0.timeout_err), 32'd0);
    chk("t5_pre_busy", 32'(bus0.busy), 32'd1);
    tick(1);
    chk("t5_tmo", 32'({bus0.timeout_err, bus1.timeout_err}), 32'd3);
    chk("t5_ack_a", 32'(bus0.ack_a), 32'd1);
    chk("t5_busy", 32'(bus0.busy), 32'd0);
    chk("t5_rdata_a", 32'(bus0.rdata_a), 32'h1234);
    req_a = 1'b0; mem_stall = 1'b0;
    tick(1);
    chk("t5_tmo_pulse", 32'(bus0.timeout_err), 32'd0);

    // Reset during WAIT of a write, then a normal read
    req_b = 1'b1; wr_b = 1'b1; addr_b = 14'h0055; wdata_b = 14'h0F0F; mem_stall = 1'b1;
    tick(5);
    chk("t6_wr_wait", 32'(bus0.mem_wr), 32'd1);
    Resetn = 1'b0;
    tick(1);
    chk("t6_rst_ctl", 32'({bus0.mem_wr, bus0.busy, bus0.ack_b}), 32'd0);
    chk("t6_rst_addr", 32'(bus0.mem_addr), 32'd0);
    req_b = 1'b0; wr_b = 1'b0; mem_stall = 1'b0; Resetn = 1'b1;
    tick(1);
    req_a = 1'b1; wr_a = 1'b0; addr_a = 14'h0777; mem_rdata = 14'h0ABC;
    tick(1);
    chk("t6_grant_addr", 32'(bus0.mem_addr), 32'h0777);
    tick(2);
    chk("t6_ack_a", 32'(bus0.ack_a), 32'd1);
    chk("t6_rdata_a", 32'(bus0.rdata_a), 32'h0ABC);
    req_a = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
